// File: rtl/mmio_uart_responder_if.sv
// mmio_uart_responder_if
// Bundles the CPU data-memory port and the UART byte ports of the MMIO
// responder into one interface.
//
// CPU side:
//   addr[31:0]  word address (addr[1:0] ignored)
//   we[3:0]     byte write enables, any bit set means a word store
//   re          load request
//   din[31:0]   store data
//   dout[31:0]  registered load data
//   hit         combinational region decode
// UART side:
//   tx_data/tx_valid/tx_ready  byte stream to the transmitter
//   rx_data/rx_valid/rx_ready  byte stream from the receiver
//
// Modports: slave = the responder, master = the CPU/UART environment.
interface mmio_uart_responder_if;
  logic [31:0] addr;
  logic [3:0]  we;
  logic        re;
  logic [31:0] din;
  logic [31:0] dout;
  logic        hit;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport slave (
    input  addr, we, re, din, tx_ready, rx_data, rx_valid,
    output dout, hit, tx_data, tx_valid, rx_ready
  );

  modport master (
    output addr, we, re, din, tx_ready, rx_data, rx_valid,
    input  dout, hit, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/mmio_uart_responder.sv
// mmio_uart_responder
// Memory-mapped responder for the 0x8xxx_xxxx data region. Offsets
// (addr[7:2], addr[27:8] ignored):
//   0x00 R  UART status {rx_overrun, rx_avail, tx_free}; read clears overrun
//   0x04 R  RX byte, pops the buffer (0 and no pop when empty)
//   0x08 W  TX byte, loaded only when the holding register is free
//   0x10 R  cycle counter
//   0x14 R  retired-instruction counter (counts only while stall is low)
//   0x18 W  clear both counters
// Loads return on dout one cycle after re is sampled; dout holds otherwise.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-low reset
//   stall        pipeline stall, suppresses access side effects
//   inst_retire  one instruction retired this cycle
//   bus          mmio_uart_responder_if.slave (CPU port + UART byte ports)
//
// Build option: define MMIO_RX_FIFO_EN for an RX_DEPTH-entry RX FIFO;
// otherwise the RX buffer is a single byte register.
//
// Handshakes: a byte moves on tx_valid & tx_ready and on rx_valid & rx_ready.
// tx_valid and rx_ready depend on registered state only. One exception on
// RX: when the buffer is full and the CPU pops in the same cycle, the byte
// on rx_data is also taken even though rx_ready is low, so the pop makes
// room for it and no overrun is flagged.
module mmio_uart_responder #(
  parameter int unsigned RX_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  inst_retire,
  mmio_uart_responder_if.slave  bus
);

  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_RX   = 8'h04;
  localparam logic [7:0] OFF_TX   = 8'h08;
  localparam logic [7:0] OFF_CYC  = 8'h10;
  localparam logic [7:0] OFF_INST = 8'h14;
  localparam logic [7:0] OFF_CLR  = 8'h18;

  logic [7:0]  offs;
  logic        acc, rd_acc, wr_acc;
  logic [31:0] rdata;

  logic [31:0] dout_q, dout_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        ovr_q, ovr_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] inst_q, inst_d;

  logic        tx_hs, tx_load, ctr_clr;
  logic        rx_avail, rx_full, rx_pop, rx_push, ovr_evt;
  logic [7:0]  rx_head;

  logic        unused_bits;
  assign unused_bits = ^{bus.addr[27:8], bus.addr[1:0], bus.din[31:8]};

  assign offs    = {bus.addr[7:2], 2'b00};
  assign bus.hit = (bus.addr[31:28] == 4'h8) && (bus.re || (|bus.we));
  assign acc     = bus.hit && !stall;
  assign rd_acc  = acc && bus.re;
  assign wr_acc  = acc && (|bus.we);

  // TX: a handshake empties the register before a same-cycle store is
  // considered, so back-to-back bytes keep tx_valid high.
  assign tx_hs   = tx_valid_q && bus.tx_ready;
  assign tx_load = wr_acc && (offs == OFF_TX) && (!tx_valid_q || tx_hs);
  assign ctr_clr = wr_acc && (offs == OFF_CLR);

  assign rx_pop  = rd_acc && (offs == OFF_RX) && rx_avail;
  assign rx_push = bus.rx_valid && (!rx_full || rx_pop);
  assign ovr_evt = bus.rx_valid && rx_full && !rx_pop;

  assign bus.rx_ready = !rx_full;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.dout     = dout_q;

`ifdef MMIO_RX_FIFO_EN
  localparam int unsigned AW = $clog2(RX_DEPTH);

  logic [7:0]  rx_mem [RX_DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;

  // Pointers carry one extra bit: equal low bits with different MSBs = full.
  assign rx_avail = (wptr_q != rptr_q);
  assign rx_full  = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rx_head  = rx_mem[rptr_q[AW-1:0]];
  assign wptr_d   = wptr_q + {{AW{1'b0}}, rx_push};
  assign rptr_d   = rptr_q + {{AW{1'b0}}, rx_pop};

  always_ff @(posedge clk) begin
    if (rst && rx_push) begin
      rx_mem[wptr_q[AW-1:0]] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
`else
  localparam int unsigned unused_rx_depth = RX_DEPTH;

  logic       rxv_q, rxv_d;
  logic [7:0] rxb_q, rxb_d;

  assign rx_avail = rxv_q;
  assign rx_full  = rxv_q;
  assign rx_head  = rxb_q;

  always_comb begin
    rxv_d = rxv_q;
    rxb_d = rxb_q;
    if (rx_pop) begin
      rxv_d = 1'b0;
    end
    if (rx_push) begin
      rxv_d = 1'b1;
      rxb_d = bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rxv_q <= 1'b0;
      rxb_q <= 8'h00;
    end else begin
      rxv_q <= rxv_d;
      rxb_q <= rxb_d;
    end
  end
`endif

  // Read mux sees pre-edge state, so a load+store returns the old value.
  always_comb begin
    rdata = 32'h0;
    case (offs)
      OFF_CTRL: rdata = {29'h0, ovr_q, rx_avail, !tx_valid_q};
      OFF_RX:   rdata = rx_avail ? {24'h0, rx_head} : 32'h0;
      OFF_CYC:  rdata = cyc_q;
      OFF_INST: rdata = inst_q;
      default:  rdata = 32'h0;
    endcase
  end

  always_comb begin
    dout_d     = rd_acc ? rdata : dout_q;

    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_hs) begin
      tx_valid_d = 1'b0;
    end
    if (tx_load) begin
      tx_valid_d = 1'b1;
      tx_data_d  = bus.din[7:0];
    end

    // Clear-on-read first, so a same-cycle overrun leaves the flag set.
    ovr_d = ovr_q;
    if (rd_acc && (offs == OFF_CTRL)) begin
      ovr_d = 1'b0;
    end
    if (ovr_evt) begin
      ovr_d = 1'b1;
    end

    cyc_d  = ctr_clr ? 32'h0 : cyc_q + 32'd1;
    inst_d = ctr_clr ? 32'h0 :
             (inst_retire && !stall) ? inst_q + 32'd1 : inst_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q     <= 32'h0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ovr_q      <= 1'b0;
      cyc_q      <= 32'h0;
      inst_q     <= 32'h0;
    end else begin
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      ovr_q      <= ovr_d;
      cyc_q      <= cyc_d;
      inst_q     <= inst_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_responder.sv
module tb_mmio_uart_responder;

  localparam int unsigned RX_DEPTH = 8;
`ifdef MMIO_RX_FIFO_EN
  localparam int unsigned MODEL_DEPTH = RX_DEPTH;
`else
  localparam int unsigned MODEL_DEPTH = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic inst_retire = 1'b0;

  always #5 clk = ~clk;

  mmio_uart_responder_if bus ();

  mmio_uart_responder #(.RX_DEPTH(RX_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .inst_retire (inst_retire),
    .bus         (bus.slave)
  );

  // ---------------- reference model state ----------------
  logic [7:0]  m_rxq[$];
  logic        m_tx_busy = 1'b0;
  logic [7:0]  m_tx_byte = 8'h00;
  logic        m_ovr = 1'b0;
  logic [31:0] m_cyc = 32'h0;
  logic [31:0] m_inst = 32'h0;
  logic [31:0] exp_q[$];

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs that were present
  // at that edge (inputs are not changed until this returns).
  task automatic model_update();
    logic [7:0]  off;
    logic        acc, rd, wr, pop, clr;
    logic [31:0] val;
    if (!rst) begin
      m_rxq.delete();
      m_tx_busy = 1'b0;
      m_tx_byte = 8'h00;
      m_ovr     = 1'b0;
      m_cyc     = 32'h0;
      m_inst    = 32'h0;
    end else begin
      off = {bus.addr[7:2], 2'b00};
      acc = (bus.addr[31:28] == 4'h8) && (bus.re || bus.we != 4'h0) && !stall;
      rd  = acc && bus.re;
      wr  = acc && (bus.we != 4'h0);
      val = 32'h0;
      if (off == 8'h00) val = {29'h0, m_ovr, m_rxq.size() != 0, !m_tx_busy};
      else if (off == 8'h04) val = (m_rxq.size() != 0) ? {24'h0, m_rxq[0]} : 32'h0;
      else if (off == 8'h10) val = m_cyc;
      else if (off == 8'h14) val = m_inst;
      if (rd) exp_q.push_back(val);
      // transmit: hand-off first, then a store may refill
      if (m_tx_busy && bus.tx_ready) m_tx_busy = 1'b0;
      if (wr && off == 8'h08 && !m_tx_busy) begin
        m_tx_busy = 1'b1;
        m_tx_byte = bus.din[7:0];
      end
      // receive: the pop frees a slot before the incoming byte is considered
      pop = rd && off == 8'h04 && m_rxq.size() != 0;
      if (pop) void'(m_rxq.pop_front());
      if (rd && off == 8'h00) m_ovr = 1'b0;
      if (bus.rx_valid) begin
        if (m_rxq.size() < MODEL_DEPTH) m_rxq.push_back(bus.rx_data);
        else m_ovr = 1'b1;
      end
      clr = wr && off == 8'h18;
      m_cyc  = clr ? 32'h0 : m_cyc + 32'd1;
      m_inst = clr ? 32'h0 : m_inst + ((inst_retire && !stall) ? 32'd1 : 32'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    mon_en = 1'b1;
  endtask

  task automatic set_idle();
    bus.addr = 32'h0;
    bus.we = 4'h0;
    bus.re = 1'b0;
    bus.din = 32'h0;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    stall = 1'b0;
    inst_retire = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off);
    bus.addr = {24'h800000, off};
    bus.re = 1'b1;
    step();
    bus.re = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] data);
    bus.addr = {24'h800000, off};
    bus.we = 4'hF;
    bus.din = data;
    step();
    bus.we = 4'h0;
  endtask

  task automatic push_rx(input logic [7:0] data);
    bus.rx_valid = 1'b1;
    bus.rx_data = data;
    step();
    bus.rx_valid = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic ld_seen = 1'b0;

  always @(posedge clk) begin
    ld_seen = rst && bus.re && !stall && (bus.addr[31:28] == 4'h8);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (ld_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL load_dout actual=0x%08h expected=<none queued> at %0t", bus.dout, $time);
        end else begin
          check("load_dout", bus.dout, exp_q.pop_front());
        end
      end
      check("hit", {31'h0, bus.hit},
            {31'h0, (bus.addr[31:28] == 4'h8) && (bus.re || bus.we != 4'h0)});
      check("tx_valid", {31'h0, bus.tx_valid}, {31'h0, m_tx_busy});
      if (m_tx_busy) check("tx_data", {24'h0, bus.tx_data}, {24'h0, m_tx_byte});
      check("rx_ready", {31'h0, bus.rx_ready}, {31'h0, m_rxq.size() < MODEL_DEPTH});
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] off_tbl [8];

  initial begin
    off_tbl[0] = 8'h00; off_tbl[1] = 8'h04; off_tbl[2] = 8'h08; off_tbl[3] = 8'h0C;
    off_tbl[4] = 8'h10; off_tbl[5] = 8'h14; off_tbl[6] = 8'h18; off_tbl[7] = 8'h40;

    set_idle();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;

    // reset values
    check("rst_dout", bus.dout, 32'h0);
    check("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    check("rst_rx_ready", {31'h0, bus.rx_ready}, 32'h1);

    rd(8'h00);
    check("ctrl_after_reset", bus.dout, 32'h1);
    step();

    // TX holding register, dropped second write, handshake
    wr(8'h08, 32'h41);
    repeat (5) step();
    wr(8'h08, 32'h42);
    check("tx_kept_first", {24'h0, bus.tx_data}, 32'h41);
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    rd(8'h00);

    // RX fill, overrun, drain
    for (int i = 0; i < 9; i++) push_rx(8'h10 + 8'(i));
    rd(8'h00);
    for (int i = 0; i < 9; i++) rd(8'h04);

    // full buffer: pop and push in the same cycle
    for (int i = 0; i < int'(MODEL_DEPTH); i++) push_rx(8'h20 + 8'(i));
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h99;
    rd(8'h04);
    bus.rx_valid = 1'b0;
    rd(8'h00);
    for (int i = 0; i < int'(MODEL_DEPTH) + 1; i++) rd(8'h04);

    // counters with stall
    wr(8'h18, 32'hDEAD);
    inst_retire = 1'b1;
    for (int i = 0; i < 100; i++) begin
      stall = (i >= 40 && i < 60);
      step();
    end
    stall = 1'b0;
    inst_retire = 1'b0;
    rd(8'h10);
    rd(8'h14);

    // cycle counter wrap
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_q;
    m_cyc = 32'hFFFF_FFFF;
    step();
    rd(8'h10);

    // clear beats increment
    inst_retire = 1'b1;
    wr(8'h18, 32'h0);
    inst_retire = 1'b0;
    rd(8'h10);
    rd(8'h14);

    // stalled read does not pop
    push_rx(8'h5A);
    stall = 1'b1;
    rd(8'h04);
    stall = 1'b0;
    rd(8'h04);
    rd(8'h04);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] off;
      int idx;
      idx = $urandom_range(0, 7);
      if (idx == 6 && $urandom_range(0, 7) != 0) idx = 1;
      off = off_tbl[idx] | 8'($urandom_range(0, 3));
      bus.addr = {($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'h8,
                  20'($urandom), off};
      bus.re = ($urandom_range(0, 2) == 0);
      bus.we = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      bus.din = $urandom;
      bus.tx_ready = ($urandom_range(0, 9) < 4);
      bus.rx_valid = ($urandom_range(0, 9) < 4);
      bus.rx_data = 8'($urandom);
      stall = ($urandom_range(0, 99) < 15);
      inst_retire = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 499) != 0);
      step();
    end

    set_idle();
    rst = 1'b1;
    repeat (3) step();
    check("exp_q_drained", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
